// File: rtl/usrp_tag_symb_integrator.sv
// usrp_tag_symb_integrator
// Integrate-and-dump stage for the tag RX baseband IQ stream. Accumulates
// NSIG samples per symbol, then emits one scaled, saturated complex sum tagged
// with its symbol index. out_tlast marks the NSYMB-th symbol of a frame.
// Optional build macro TAG_INTEG_OVF_CNT_EN adds a 16-bit saturating count of
// dumps in which I or Q clipped.
module usrp_tag_symb_integrator #(
   parameter int DATA_WIDTH  = 16,
   parameter int ACC_WIDTH   = 40,
   parameter int OUT_WIDTH   = 32,
   parameter int OUT_SHIFT   = 18,
   parameter int NSIG_WIDTH  = 24,
   parameter int NSYMB_WIDTH = 16,
   parameter int NSIG        = 262144,
   parameter int NSYMB       = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          srst,
   input  logic signed [DATA_WIDTH-1:0]  irx_bb,
   input  logic signed [DATA_WIDTH-1:0]  qrx_bb,
   input  logic                          in_tvalid,
   output logic                          in_tready,
   output logic signed [OUT_WIDTH-1:0]   out_i,
   output logic signed [OUT_WIDTH-1:0]   out_q,
   output logic [NSYMB_WIDTH-1:0]        out_symb,
   output logic                          out_tvalid,
   output logic                          out_tlast,
   input  logic                          out_tready,
   output logic                          ovf
`ifdef TAG_INTEG_OVF_CNT_EN
   ,
   output logic [15:0]                   ovf_cnt
`endif
);

   localparam logic [NSIG_WIDTH-1:0]  LAST_SAMPLE = NSIG_WIDTH'(NSIG - 1);
   localparam logic [NSYMB_WIDTH-1:0] LAST_SYMB   = NSYMB_WIDTH'(NSYMB);
   localparam logic [NSYMB_WIDTH-1:0] FIRST_SYMB  = NSYMB_WIDTH'(1);

   logic [NSIG_WIDTH-1:0]         count;
   logic [NSYMB_WIDTH-1:0]        symb;
   logic signed [ACC_WIDTH-1:0]   acc_i, acc_q;
   logic signed [ACC_WIDTH-1:0]   ext_i, ext_q;
   logic signed [ACC_WIDTH-1:0]   sum_i, sum_q;
   logic signed [ACC_WIDTH-1:0]   scaled_i, scaled_q;
   logic signed [OUT_WIDTH-1:0]   res_i, res_q;
   logic                          clip_i, clip_q;
   logic                          is_last, xfer, dump;

   // Clamp a scaled accumulator to the output range; MSB of the result flags clipping.
   function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
      logic [ACC_WIDTH-OUT_WIDTH:0] top;
      top = v[ACC_WIDTH-1:OUT_WIDTH-1];
      if ((&top) || !(|top))
         return {1'b0, v[OUT_WIDTH-1:0]};
      else if (v[ACC_WIDTH-1])
         return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
      else
         return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
   endfunction

   assign ext_i = {{(ACC_WIDTH-DATA_WIDTH){irx_bb[DATA_WIDTH-1]}}, irx_bb};
   assign ext_q = {{(ACC_WIDTH-DATA_WIDTH){qrx_bb[DATA_WIDTH-1]}}, qrx_bb};

   assign is_last   = (count == LAST_SAMPLE);
   assign in_tready = !(is_last && out_tvalid && !out_tready);
   assign xfer      = in_tvalid && in_tready;
   assign dump      = xfer && is_last;

   // Running sum including the current sample, scaled by a flooring shift and clamped.
   always_comb begin
      sum_i    = acc_i + ext_i;
      sum_q    = acc_q + ext_q;
      scaled_i = sum_i >>> OUT_SHIFT;
      scaled_q = sum_q >>> OUT_SHIFT;
      {clip_i, res_i} = saturate(scaled_i);
      {clip_q, res_q} = saturate(scaled_q);
   end

   // Input side: accumulate accepted samples and advance the sample/symbol counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_i <= '0;
         acc_q <= '0;
         count <= '0;
         symb  <= FIRST_SYMB;
      end else if (srst) begin
         acc_i <= '0;
         acc_q <= '0;
         count <= '0;
         symb  <= FIRST_SYMB;
      end else if (dump) begin
         acc_i <= '0;
         acc_q <= '0;
         count <= '0;
         symb  <= (symb == LAST_SYMB) ? FIRST_SYMB : symb + FIRST_SYMB;
      end else if (xfer) begin
         acc_i <= sum_i;
         acc_q <= sum_q;
         count <= count + NSIG_WIDTH'(1);
      end
   end

   // Output register: a dump always loads, otherwise acceptance empties the slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_i      <= '0;
         out_q      <= '0;
         out_symb   <= '0;
         out_tvalid <= 1'b0;
         out_tlast  <= 1'b0;
         ovf        <= 1'b0;
      end else if (srst) begin
         out_i      <= '0;
         out_q      <= '0;
         out_symb   <= '0;
         out_tvalid <= 1'b0;
         out_tlast  <= 1'b0;
         ovf        <= 1'b0;
      end else if (dump) begin
         out_i      <= res_i;
         out_q      <= res_q;
         out_symb   <= symb;
         out_tvalid <= 1'b1;
         out_tlast  <= (symb == LAST_SYMB);
         ovf        <= ovf || clip_i || clip_q;
      end else if (out_tready) begin
         out_tvalid <= 1'b0;
      end
   end

`ifdef TAG_INTEG_OVF_CNT_EN
   // Count dumps that clipped on either rail, holding at the maximum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ovf_cnt <= '0;
      else if (srst)
         ovf_cnt <= '0;
      else if (dump && (clip_i || clip_q) && (ovf_cnt != 16'hFFFF))
         ovf_cnt <= ovf_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_usrp_tag_symb_integrator.sv
// Testbench for usrp_tag_symb_integrator: two instances (OUT_SHIFT 2 and 0)
// driven by the same stream and checked every cycle against a sample-level
// model, plus literal expectations for the directed scenarios.
module tb_usrp_tag_symb_integrator;

   localparam int NSIG  = 4;
   localparam int NSYMB = 3;

   logic clk = 1'b0;
   logic reset, srst, in_tvalid, out_tready;
   logic signed [15:0] irx_bb, qrx_bb;

   logic in_tready, out_tvalid, out_tlast, ovf;
   logic signed [15:0] out_i, out_q;
   logic [15:0] out_symb;
   logic s_in_tready, s_out_tvalid, s_out_tlast, s_ovf;
   logic signed [15:0] s_out_i, s_out_q;
   logic [15:0] s_out_symb;
`ifdef TAG_INTEG_OVF_CNT_EN
   logic [15:0] ovf_cnt, s_ovf_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   usrp_tag_symb_integrator #(.OUT_WIDTH(16), .OUT_SHIFT(2), .NSIG(NSIG), .NSYMB(NSYMB)) dut (
      .clk(clk), .reset(reset), .srst(srst), .irx_bb(irx_bb), .qrx_bb(qrx_bb),
      .in_tvalid(in_tvalid), .in_tready(in_tready), .out_i(out_i), .out_q(out_q),
      .out_symb(out_symb), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
      .out_tready(out_tready), .ovf(ovf)
`ifdef TAG_INTEG_OVF_CNT_EN
      , .ovf_cnt(ovf_cnt)
`endif
   );

   usrp_tag_symb_integrator #(.OUT_WIDTH(16), .OUT_SHIFT(0), .NSIG(NSIG), .NSYMB(NSYMB)) dut_sat (
      .clk(clk), .reset(reset), .srst(srst), .irx_bb(irx_bb), .qrx_bb(qrx_bb),
      .in_tvalid(in_tvalid), .in_tready(s_in_tready), .out_i(s_out_i), .out_q(s_out_q),
      .out_symb(s_out_symb), .out_tvalid(s_out_tvalid), .out_tlast(s_out_tlast),
      .out_tready(out_tready), .ovf(s_ovf)
`ifdef TAG_INTEG_OVF_CNT_EN
      , .ovf_cnt(s_ovf_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Floor-shift then clamp into the signed 16-bit output range.
   function automatic longint sat_shift(input longint s, input int sh);
      longint r;
      r = s >>> sh;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      return r;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sums of accepted samples per symbol, one-entry output slot.
   longint m_sum_i, m_sum_q;
   int     m_n, m_symb, m_osymb;
   bit     m_valid, m_last, took;
   longint m_i[2], m_q[2];
   bit     m_ovf[2];
   int     m_ovfcnt[2];

   function automatic bit exp_ready();
      return !(m_n == NSIG - 1 && m_valid && !out_tready);
   endfunction

   // Model update on each clock edge, or immediately on async reset.
   always @(posedge clk or posedge reset) begin
      bit rdy;
      took = 1'b0;
      if (reset || srst) begin
         m_sum_i = 0; m_sum_q = 0; m_n = 0; m_symb = 1; m_osymb = 0;
         m_valid = 1'b0; m_last = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_i[k] = 0; m_q[k] = 0; m_ovf[k] = 1'b0; m_ovfcnt[k] = 0;
         end
      end else begin
         rdy = exp_ready();
         if (m_valid && out_tready) m_valid = 1'b0;
         if (in_tvalid && rdy) begin
            took = 1'b1;
            m_sum_i += irx_bb;
            m_sum_q += qrx_bb;
            if (m_n == NSIG - 1) begin
               for (int k = 0; k < 2; k++) begin
                  int sh;
                  bit clipped;
                  sh = (k == 0) ? 2 : 0;
                  m_i[k] = sat_shift(m_sum_i, sh);
                  m_q[k] = sat_shift(m_sum_q, sh);
                  clipped = (m_i[k] != (m_sum_i >>> sh)) || (m_q[k] != (m_sum_q >>> sh));
                  if (clipped) begin
                     m_ovf[k] = 1'b1;
                     if (m_ovfcnt[k] < 65535) m_ovfcnt[k]++;
                  end
               end
               m_valid = 1'b1;
               m_osymb = m_symb;
               m_last  = (m_symb == NSYMB);
               m_symb  = (m_symb == NSYMB) ? 1 : m_symb + 1;
               m_sum_i = 0; m_sum_q = 0; m_n = 0;
            end else begin
               m_n++;
            end
         end
      end
   end

   typedef struct { longint i; longint q; int symb; bit last; } ent_t;
   ent_t outlog[$];

   // Per-cycle comparison on the falling edge, plus a log of accepted outputs.
   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("in_tready", in_tready, exp_ready());
         checkOutput("s_in_tready", s_in_tready, exp_ready());
         checkOutput("out_tvalid", out_tvalid, m_valid);
         checkOutput("s_out_tvalid", s_out_tvalid, m_valid);
         checkOutput("ovf", ovf, m_ovf[0]);
         checkOutput("s_ovf", s_ovf, m_ovf[1]);
`ifdef TAG_INTEG_OVF_CNT_EN
         checkOutput("ovf_cnt", ovf_cnt, m_ovfcnt[0]);
         checkOutput("s_ovf_cnt", s_ovf_cnt, m_ovfcnt[1]);
`endif
         if (m_valid) begin
            checkOutput("out_i", out_i, m_i[0]);
            checkOutput("out_q", out_q, m_q[0]);
            checkOutput("out_symb", out_symb, m_osymb);
            checkOutput("out_tlast", out_tlast, m_last);
            checkOutput("s_out_i", s_out_i, m_i[1]);
            checkOutput("s_out_q", s_out_q, m_q[1]);
            checkOutput("s_out_symb", s_out_symb, m_osymb);
            checkOutput("s_out_tlast", s_out_tlast, m_last);
         end
         if (out_tvalid && out_tready)
            outlog.push_back('{i: out_i, q: out_q, symb: int'(out_symb), last: out_tlast});
      end
   end

   // Present one sample until accepted; releases a stuck out_tready after a few cycles.
   task automatic applyStimulus(input longint i, input longint q);
      int n;
      irx_bb = 16'(i);
      qrx_bb = 16'(q);
      in_tvalid = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (!took && n == 3) out_tready = 1'b1;
      end while (!took && n < 50);
      checkOutput("sample_accept_timeout", took, 1);
      in_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_tvalid = 1'b0;
      repeat (n) begin
         irx_bb = 16'($urandom);
         qrx_bb = 16'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic softReset();
      srst = 1'b1;
      @(posedge clk); #1;
      srst = 1'b0;
      outlog.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      longint gi[24], gq[24];
      reset = 1'b1; srst = 1'b0; in_tvalid = 1'b0; out_tready = 1'b1;
      irx_bb = '0; qrx_bb = '0;
      #1;
      $display("[TB] reset state");
      checkOutput("rst_out_tvalid", out_tvalid, 0);
      checkOutput("rst_out_symb", out_symb, 0);
      checkOutput("rst_out_i", out_i, 0);
      checkOutput("rst_ovf", ovf, 0);
      checkOutput("rst_in_tready", in_tready, 1);
      #20;
      @(posedge clk); #1;
      reset = 1'b0;

      $display("[TB] steady stream of 12 samples");
      for (int k = 0; k < 4; k++) applyStimulus(100, -8);
      checkOutput("t1_latency_valid", out_tvalid, 1);
      for (int k = 0; k < 8; k++) applyStimulus(100, -8);
      idle(3);
      checkOutput("t1_count", outlog.size(), 3);
      for (int k = 0; k < 3 && k < outlog.size(); k++) begin
         checkOutput("t1_i", outlog[k].i, 100);
         checkOutput("t1_q", outlog[k].q, -8);
         checkOutput("t1_symb", outlog[k].symb, k + 1);
         checkOutput("t1_last", outlog[k].last, (k == 2) ? 1 : 0);
      end

      $display("[TB] output backpressure");
      softReset();
      for (int k = 0; k < 3; k++) applyStimulus(100, -8);
      out_tready = 1'b0;
      for (int k = 0; k < 4; k++) applyStimulus(100, -8);
      irx_bb = 100; qrx_bb = -8; in_tvalid = 1'b1;
      #1;
      checkOutput("bp_stall_ready", in_tready, 0);
      @(posedge clk); #1;
      checkOutput("bp_stall_took", took, 0);
      checkOutput("bp_hold_valid", out_tvalid, 1);
      checkOutput("bp_hold_i", out_i, 100);
      checkOutput("bp_hold_symb", out_symb, 1);
      out_tready = 1'b1;
      #1;
      checkOutput("bp_release_ready", in_tready, 1);
      @(posedge clk); #1;
      in_tvalid = 1'b0;
      checkOutput("bp_release_took", took, 1);
      checkOutput("bp_out2_valid", out_tvalid, 1);
      checkOutput("bp_out2_symb", out_symb, 2);
      idle(2);
      checkOutput("bp_count", outlog.size(), 2);

      $display("[TB] saturation");
      softReset();
      for (int k = 0; k < 4; k++) applyStimulus(32767, 0);
      checkOutput("sat_pos_i", s_out_i, 32767);
      checkOutput("sat_pos_ovf", s_ovf, 1);
      checkOutput("sat_pos_main_i", out_i, 32767);
      checkOutput("sat_pos_main_ovf", ovf, 0);
`ifdef TAG_INTEG_OVF_CNT_EN
      checkOutput("sat_pos_ovf_cnt", s_ovf_cnt, 1);
`endif
      for (int k = 0; k < 4; k++) applyStimulus(-32768, 0);
      checkOutput("sat_neg_i", s_out_i, -32768);
      checkOutput("sat_neg_main_i", out_i, -32768);
`ifdef TAG_INTEG_OVF_CNT_EN
      checkOutput("sat_neg_ovf_cnt", s_ovf_cnt, 2);
`endif

      $display("[TB] negative floor");
      softReset();
      applyStimulus(-1, 0); applyStimulus(-1, 0); applyStimulus(-1, 0); applyStimulus(0, 0);
      checkOutput("floor_i", out_i, -1);
      checkOutput("floor_q", out_q, 0);

      $display("[TB] async reset mid-symbol");
      for (int k = 0; k < 4; k++) applyStimulus(32767, 5);
      out_tready = 1'b0;
      for (int k = 0; k < 4; k++) applyStimulus(5, 3);
      applyStimulus(1, 1); applyStimulus(1, 1);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("areset_out_i", out_i, 0);
      checkOutput("areset_out_q", out_q, 0);
      checkOutput("areset_out_symb", out_symb, 0);
      checkOutput("areset_out_tvalid", out_tvalid, 0);
      checkOutput("areset_s_ovf", s_ovf, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      out_tready = 1'b1;
      outlog.delete();
      applyStimulus(7, -1); applyStimulus(8, -2); applyStimulus(9, -3); applyStimulus(10, -4);
      idle(2);
      checkOutput("areset_count", outlog.size(), 1);
      if (outlog.size() > 0) begin
         checkOutput("areset_sum_i", outlog[0].i, 8);
         checkOutput("areset_sum_q", outlog[0].q, -3);
         checkOutput("areset_symb", outlog[0].symb, 1);
      end

      $display("[TB] gapped random stream");
      softReset();
      for (int k = 0; k < 24; k++) begin
         gi[k] = longint'($signed(16'($urandom)));
         gq[k] = longint'($signed(16'($urandom)));
         idle($urandom_range(0, 2));
         out_tready = ($urandom_range(0, 3) != 0);
         applyStimulus(gi[k], gq[k]);
      end
      out_tready = 1'b1;
      idle(3);
      checkOutput("rand_count", outlog.size(), 6);
      for (int s = 0; s < 6 && s < outlog.size(); s++) begin
         longint si, sq;
         si = 0; sq = 0;
         for (int j = 0; j < 4; j++) begin
            si += gi[4*s + j];
            sq += gq[4*s + j];
         end
         checkOutput("rand_i", outlog[s].i, sat_shift(si, 2));
         checkOutput("rand_q", outlog[s].q, sat_shift(sq, 2));
         checkOutput("rand_symb", outlog[s].symb, (s % 3) + 1);
         checkOutput("rand_last", outlog[s].last, (s % 3 == 2) ? 1 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
